// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dram_responder
// Purpose  : Fixed-latency line-wide DRAM model. Accepts one request per
//            handshake (cs held until ack), completes it LATENCY cycles
//            after acceptance with a one-cycle ack pulse, then waits for the
//            initiator to release cs before accepting another request.
// Ports    : clk        - sole clock, rising edge
//            rst        - synchronous active-high reset
//            dram_cs    - request strobe, held until ack seen
//            dram_we    - 1 = write line, 0 = read line
//            dram_addr  - line address (low DEPTH_LOG2 bits index storage)
//            dram_wdata - write line data
//            dram_rdata - registered read data, held until next read completes
//            dram_ack   - one-cycle completion pulse
//            busy       - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module dram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_WIDTH = 256,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dram_cs,
  input  logic                  dram_we,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [LINE_WIDTH-1:0] dram_wdata,
  output logic [LINE_WIDTH-1:0] dram_rdata,
  output logic                  dram_ack,
  output logic                  busy
);

  localparam int        DEPTH   = 1 << DEPTH_LOG2;
  // Countdown starts at LATENCY-1 so that the ACK-entering edge is exactly
  // LATENCY edges after acceptance (LATENCY=1 loads 0 and exits next edge).
  localparam logic [7:0] CD_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                  state;
  logic [7:0]              count;
  logic                    req_we;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [LINE_WIDTH-1:0]   req_wdata;

  logic [LINE_WIDTH-1:0]   mem [DEPTH];

  // Upper address bits alias onto the same lines and are intentionally dropped.
  generate
    if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^dram_addr[ADDR_WIDTH-1:DEPTH_LOG2];
    end
  endgenerate

  // Completion happens on the edge that leaves WAIT towards ACK; an abort
  // (cs low) on that same edge wins and suppresses the completion.
  logic complete;
  assign complete = (state == ST_WAIT) && dram_cs && (count == 8'd0);

  // Storage is not reset: contents survive rst, only the in-flight
  // transaction is cancelled.
  always_ff @(posedge clk) begin
    if (!rst && complete && req_we) begin
      mem[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= 8'd0;
      req_we     <= 1'b0;
      req_idx    <= '0;
      req_wdata  <= '0;
      dram_rdata <= '0;
      dram_ack   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dram_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dram_cs) begin
            req_we    <= dram_we;
            req_idx   <= dram_addr[DEPTH_LOG2-1:0];
            req_wdata <= dram_wdata;
            count     <= CD_LOAD;
            state     <= ST_WAIT;
            busy      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!dram_cs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (count == 8'd0) begin
            state    <= ST_ACK;
            dram_ack <= 1'b1;
            if (!req_we) begin
              dram_rdata <= mem[req_idx];
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        ST_ACK: begin
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!dram_cs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_responder
// Purpose  : Directed self-checking bench for dram_responder. Three instances:
//            0: LATENCY=10, DEPTH_LOG2=10   1: LATENCY=1, DEPTH_LOG2=10
//            2: LATENCY=3,  DEPTH_LOG2=4 (address aliasing)
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_responder;

  localparam logic [255:0] P_A5 = {32{8'hA5}};
  localparam logic [255:0] P_5A = {32{8'h5A}};
  localparam logic [255:0] P_77 = {32{8'h77}};
  localparam logic [255:0] P_11 = {32{8'h11}};
  localparam logic [255:0] P_CC = {32{8'hCC}};
  localparam logic [255:0] P_DD = {32{8'hDD}};
  localparam logic [255:0] P_3C = {32{8'h3C}};
  localparam logic [255:0] P_33 = {32{8'h33}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cs    [3];
  logic         we    [3];
  logic [9:0]   addr  [3];
  logic [255:0] wdata [3];
  logic [255:0] rdata [3];
  logic         ack   [3];
  logic         busy  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dram_responder #(.ADDR_WIDTH(10), .LINE_WIDTH(256), .DEPTH_LOG2(10), .LATENCY(10)) u_lat10 (
    .clk(clk), .rst(rst), .dram_cs(cs[0]), .dram_we(we[0]), .dram_addr(addr[0]),
    .dram_wdata(wdata[0]), .dram_rdata(rdata[0]), .dram_ack(ack[0]), .busy(busy[0])
  );

  dram_responder #(.ADDR_WIDTH(10), .LINE_WIDTH(256), .DEPTH_LOG2(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .dram_cs(cs[1]), .dram_we(we[1]), .dram_addr(addr[1]),
    .dram_wdata(wdata[1]), .dram_rdata(rdata[1]), .dram_ack(ack[1]), .busy(busy[1])
  );

  dram_responder #(.ADDR_WIDTH(10), .LINE_WIDTH(256), .DEPTH_LOG2(4), .LATENCY(3)) u_d4 (
    .clk(clk), .rst(rst), .dram_cs(cs[2]), .dram_we(we[2]), .dram_addr(addr[2]),
    .dram_wdata(wdata[2]), .dram_rdata(rdata[2]), .dram_ack(ack[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake on instance id. Sample index i is taken #1 after the i-th
  // edge, where edge 0 is the acceptance edge. Inputs are scrambled after
  // acceptance to show the latched request is what completes. cs drops once
  // ack is seen; busy must stay high through sample lat+1 (ACK->RELEASE) and
  // be low at lat+2 (RELEASE->IDLE).
  task automatic txn(input int id, input int lat, input logic w, input logic [9:0] a,
                     input logic [255:0] d, output int ack_at, output int n_ack,
                     output logic busy_ok);
    cs[id] = 1'b1; we[id] = w; addr[id] = a; wdata[id] = d;
    ack_at = -1; n_ack = 0; busy_ok = 1'b1;
    for (int i = 0; i <= lat + 2; i++) begin
      tick();
      if (ack[id] === 1'b1) begin
        n_ack++;
        if (ack_at < 0) ack_at = i;
        cs[id] = 1'b0;
      end else if (i == 1) begin
        we[id] = ~w; addr[id] = a + 10'd1; wdata[id] = ~d;
      end
      if (busy[id] !== ((i <= lat + 1) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
    end
    cs[id] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ack_at, n_ack, cnt;
    logic bok;

    for (int k = 0; k < 3; k++) begin
      cs[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ack",   256'(ack[0]),  256'(0));
    chk("rst_busy",  256'(busy[0]), 256'(0));
    chk("rst_rdata", rdata[0],      '0);
    chk("rst_busy_lat1", 256'(busy[1]), 256'(0));

    // Write 0x005 = A5..A5, ack exactly 10 edges after acceptance
    txn(0, 10, 1'b1, 10'h005, P_A5, ack_at, n_ack, bok);
    chk("wr5_ack_at", 256'(ack_at), 256'(10));
    chk("wr5_ack_n",  256'(n_ack),  256'(1));
    chk("wr5_busy",   256'(bok),    256'(1));
    chk("wr5_rdata_untouched", rdata[0], '0);

    // Read 0x005
    txn(0, 10, 1'b0, 10'h005, '0, ack_at, n_ack, bok);
    chk("rd5_ack_at", 256'(ack_at), 256'(10));
    chk("rd5_ack_n",  256'(n_ack),  256'(1));
    chk("rd5_rdata",  rdata[0],     P_A5);

    // Write 0x006 leaves rdata alone
    txn(0, 10, 1'b1, 10'h006, P_5A, ack_at, n_ack, bok);
    chk("wr6_ack_at", 256'(ack_at), 256'(10));
    chk("wr6_rdata_held", rdata[0], P_A5);

    // Known contents for 0x007, then abort a write of 11..11 in the 4th WAIT cycle
    txn(0, 10, 1'b1, 10'h007, P_77, ack_at, n_ack, bok);
    cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'h007; wdata[0] = P_11;
    cnt = 0;
    for (int i = 0; i <= 3; i++) begin
      tick();
      if (ack[0] === 1'b1) cnt++;
    end
    cs[0] = 1'b0;
    tick();
    chk("abort_busy", 256'(busy[0]), 256'(0));
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ack[0] !== 1'b0) cnt++;
    end
    chk("abort_no_ack", 256'(cnt), 256'(0));
    chk("abort_rdata_held", rdata[0], P_A5);

    txn(0, 10, 1'b0, 10'h007, '0, ack_at, n_ack, bok);
    chk("rd7_after_abort", rdata[0], P_77);

    // Read 0x006 (its write had inputs scrambled after acceptance)
    txn(0, 10, 1'b0, 10'h006, '0, ack_at, n_ack, bok);
    chk("rd6_latched", rdata[0], P_5A);

    // Reset mid-write of 0x008, with cs still high on the reset edge
    txn(0, 10, 1'b1, 10'h008, P_CC, ack_at, n_ack, bok);
    cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'h008; wdata[0] = P_DD;
    cnt = 0;
    for (int i = 0; i <= 2; i++) begin
      tick();
      if (ack[0] === 1'b1) cnt++;
    end
    rst = 1'b1;
    tick();
    chk("midrst_busy",  256'(busy[0]), 256'(0));
    chk("midrst_ack",   256'(ack[0]),  256'(0));
    chk("midrst_rdata", rdata[0],      '0);
    rst = 1'b0;
    cs[0] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ack[0] !== 1'b0) cnt++;
    end
    chk("midrst_no_ack", 256'(cnt), 256'(0));
    txn(0, 10, 1'b0, 10'h008, '0, ack_at, n_ack, bok);
    chk("rd8_unmodified", rdata[0], P_CC);

    // LATENCY=1: write, then read holding cs 3 cycles past ack
    txn(1, 1, 1'b1, 10'h003, P_3C, ack_at, n_ack, bok);
    chk("l1_wr_ack_at", 256'(ack_at), 256'(1));
    chk("l1_wr_busy",   256'(bok),    256'(1));
    cs[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h003;
    cnt = 0; ack_at = -1; bok = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (ack[1] === 1'b1) begin
        cnt++;
        if (ack_at < 0) ack_at = i;
      end
      if (busy[1] !== 1'b1) bok = 1'b0;
    end
    chk("l1_rd_ack_at", 256'(ack_at), 256'(1));
    chk("l1_rd_ack_n",  256'(cnt),    256'(1));
    chk("l1_release_busy", 256'(bok), 256'(1));
    chk("l1_rd_rdata", rdata[1], P_3C);
    cs[1] = 1'b0;
    tick();
    chk("l1_release_exit", 256'(busy[1]), 256'(0));

    // DEPTH_LOG2=4: 0x013 aliases onto 0x003
    txn(2, 3, 1'b1, 10'h013, P_33, ack_at, n_ack, bok);
    chk("d4_wr_ack_at", 256'(ack_at), 256'(3));
    txn(2, 3, 1'b0, 10'h003, '0, ack_at, n_ack, bok);
    chk("d4_rd_ack_at", 256'(ack_at), 256'(3));
    chk("d4_alias_rdata", rdata[2], P_33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning line-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 256, meaning data line width in bits.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of storage depth in lines.
REQ-004 SHALL have parameter LATENCY, default 10, meaning cycles from request acceptance to ack; legal range 1..255.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port dram_cs  input  1  request strobe, held high by initiator until ack seen.
REQ-008 SHALL have port dram_we  input  1  1 = write line, 0 = read line; qualified by dram_cs.
REQ-009 SHALL have port dram_addr  input  ADDR_WIDTH  line address.
REQ-010 SHALL have port dram_wdata  input  LINE_WIDTH  write line data.
REQ-011 SHALL have port dram_rdata  output  LINE_WIDTH  registered read line data.
REQ-012 SHALL have port dram_ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT, ACK, RELEASE.
REQ-015 IDLE: on edge with dram_cs=1, SHALL latch dram_we, dram_addr, dram_wdata into internal registers, load countdown with LATENCY-1, go to WAIT; else stay IDLE.
REQ-016 WAIT: on edge with dram_cs=0, SHALL abort to IDLE with no ack, no storage write; else if countdown = 0 go to ACK, else decrement.
REQ-017 Request accepted at edge E SHALL produce dram_ack=1 exactly during the cycle after edge E+LATENCY, for one cycle only.
REQ-018 On the edge entering ACK: write request SHALL update storage at latched address with latched data; read request SHALL load dram_rdata from storage at latched address.
REQ-019 dram_rdata SHALL hold its value until the next read completion; write completions and aborts SHALL NOT change it.
REQ-020 Inputs changing after acceptance SHALL NOT affect the in-flight transaction (latched values used).
REQ-021 ACK: SHALL go to RELEASE unconditionally on next edge.
REQ-022 RELEASE: SHALL stay while dram_cs=1; go to IDLE on edge with dram_cs=0; no new request accepted while in RELEASE.
REQ-023 Storage index SHALL be dram_addr[DEPTH_LOG2-1:0]; upper address bits ignored (aliasing wraps).
REQ-024 Read of a line written by a previous completed transaction SHALL return that write's data (read-after-write coherent).
REQ-025 Countdown register SHALL be 8 bits; LATENCY=1 SHALL reach ACK on the first edge after acceptance.
REQ-026 busy SHALL be 1 in WAIT, ACK, RELEASE; 0 in IDLE.

Reset
REQ-027 On edge with rst=1: state SHALL become IDLE, dram_ack=0, busy=0, dram_rdata=0, countdown=0.
REQ-028 Reset mid-transaction SHALL cancel it: no ack, no storage write.
REQ-029 Storage contents SHALL NOT be cleared by reset; initial contents undefined unless preloaded by bench.
REQ-030 rst SHALL take priority over dram_cs on the same edge.

Verification
REQ-031 LATENCY=10; write addr 0x005 data 0xA5..A5, cs held until ack -> ack single pulse exactly 10 cycles after acceptance edge; busy high throughout.
REQ-032 Then read addr 0x005 -> ack after 10 cycles with dram_rdata=0xA5..A5; rdata unchanged after next write to 0x006.
REQ-033 Drop dram_cs at 4th WAIT cycle of write to 0x007 (data 0x11..11) -> no ack, return IDLE; later read 0x007 returns prior contents.
REQ-034 Assert rst during WAIT of a write -> ack never asserted, busy=0 next cycle, dram_rdata=0, target line unmodified.
REQ-035 LATENCY=1; read request -> ack in cycle after acceptance edge; cs kept high 3 cycles after ack -> state stays RELEASE, no second ack.
REQ-036 DEPTH_LOG2=4; write addr 0x013 data 0x33..33, read addr 0x003 -> returns 0x33..33 (wrap aliasing).
